// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - frame-buffer shared types and widths; FB_PINGPONG_EN selects two-bank addressing
package fb_pkg;

  localparam int FB_FRAME_PIXELS = 307200;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_CAPTURE = 2'd1,
    W_HOLD    = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE   = 1'b0,
    R_ACTIVE = 1'b1
  } rd_state_e;

  // Pixel counter width within one bank
  function automatic int fb_cw(input int fp);
    return $clog2(fp);
  endfunction

  // BRAM address width: room for two banks when ping-pong is built in
  function automatic int fb_aw(input int fp);
`ifdef FB_PINGPONG_EN
    return $clog2(2 * fp);
`else
    return $clog2(fp);
`endif
  endfunction

  localparam int FB_CW = fb_cw(FB_FRAME_PIXELS);
  localparam int FB_AW = fb_aw(FB_FRAME_PIXELS);

endpackage

// File: rtl/fb_bank_ctrl_if.sv
// rtl/fb_bank_ctrl_if.sv - capture, BRAM and display-FIFO signals of fb_bank_ctrl; width follows FB_PINGPONG_EN
interface fb_bank_ctrl_if #(
  parameter int DATA_WIDTH   = 12,
  parameter int FRAME_PIXELS = fb_pkg::FB_FRAME_PIXELS
);
  import fb_pkg::*;

  localparam int AW = fb_aw(FRAME_PIXELS);

  logic                  i_valid;
  logic                  i_sof;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  o_mem_wr;
  logic [AW-1:0]         o_mem_waddr;
  logic [DATA_WIDTH-1:0] o_mem_wdata;
  logic [AW-1:0]         o_mem_raddr;
  logic                  i_req;
  logic                  i_almostfull;
  logic                  o_fifo_wr;
  logic                  o_wbank;
  logic                  o_rbank;
  logic                  o_drop;
  logic                  o_sync_err;

  modport master (
    output i_valid, i_sof, i_data, i_req, i_almostfull,
    input  o_mem_wr, o_mem_waddr, o_mem_wdata, o_mem_raddr,
    input  o_fifo_wr, o_wbank, o_rbank, o_drop, o_sync_err
  );

  modport slave (
    input  i_valid, i_sof, i_data, i_req, i_almostfull,
    output o_mem_wr, o_mem_waddr, o_mem_wdata, o_mem_raddr,
    output o_fifo_wr, o_wbank, o_rbank, o_drop, o_sync_err
  );

endinterface

// File: rtl/fb_addr_counter.sv
// rtl/fb_addr_counter.sv - wrapping pixel counter with enable, sync clear and terminal-count flag
module fb_addr_counter #(
  parameter int W   = 4,
  parameter int MAX = 16
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d, start;

  // Clear restarts from zero; clear together with enable counts the current beat as beat 0
  always_comb begin
    start = clr_i ? '0 : cnt_q;
    cnt_d = start;
    if (en_i) cnt_d = (start == W'(MAX - 1)) ? '0 : start + 1'b1;
  end

  // Count register
  always_ff @(posedge i_clk) begin
    if (!i_rstn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == W'(MAX - 1));

endmodule

// File: rtl/fb_bank_ctrl.sv
// rtl/fb_bank_ctrl.sv - frame-buffer writer/reader with bank swap at frame boundaries; FB_PINGPONG_EN enables two banks
module fb_bank_ctrl
  import fb_pkg::*;
#(
  parameter int DATA_WIDTH   = 12,
  parameter int FRAME_PIXELS = FB_FRAME_PIXELS
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  fb_bank_ctrl_if.slave bus
);

  localparam int AW = fb_aw(FRAME_PIXELS);
  localparam int CW = fb_cw(FRAME_PIXELS);

  wr_state_e w_state_q, w_state_d;
  rd_state_e r_state_q, r_state_d;

  logic [CW-1:0] wcnt, rcnt;
  logic          wtc, rtc;
  logic          w_accept, w_restart, w_complete, w_sync_err, w_drop;
  logic          r_issue, r_clr;
  logic          swap;
  logic [AW-1:0] wbase, rbase;

  logic                  mem_wr_q, rd_pipe_q, fifo_wr_q, drop_q, sync_err_q;
  logic [AW-1:0]         waddr_q, raddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  fb_addr_counter #(.W(CW), .MAX(FRAME_PIXELS)) u_wcnt (
    .i_clk (i_clk), .i_rstn(i_rstn), .en_i(w_accept), .clr_i(w_restart),
    .cnt_o (wcnt),  .tc_o  (wtc)
  );

  fb_addr_counter #(.W(CW), .MAX(FRAME_PIXELS)) u_rcnt (
    .i_clk (i_clk), .i_rstn(i_rstn), .en_i(r_issue), .clr_i(r_clr),
    .cnt_o (rcnt),  .tc_o  (rtc)
  );

  // Writer state register
  always_ff @(posedge i_clk) begin
    if (!i_rstn) w_state_q <= W_IDLE;
    else         w_state_q <= w_state_d;
  end

  // Writer next state; a completed frame parks in W_HOLD until the reader takes it
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:    if (bus.i_valid && bus.i_sof) w_state_d = W_CAPTURE;
      W_CAPTURE: begin
        if (w_complete) begin
`ifdef FB_PINGPONG_EN
          w_state_d = swap ? W_IDLE : W_HOLD;
`else
          w_state_d = W_IDLE;
`endif
        end
      end
`ifdef FB_PINGPONG_EN
      W_HOLD:    if (swap) w_state_d = W_IDLE;
`endif
      default:   w_state_d = W_IDLE;
    endcase
  end

  // Writer per-cycle decisions: accept, frame restart, completion, error/drop flags
  always_comb begin
    w_accept   = 1'b0;
    w_restart  = 1'b0;
    w_complete = 1'b0;
    w_sync_err = 1'b0;
    w_drop     = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        w_accept  = bus.i_valid && bus.i_sof;
        w_restart = bus.i_valid && bus.i_sof;
      end
      W_CAPTURE: begin
        w_accept   = bus.i_valid;
        w_restart  = bus.i_valid && bus.i_sof;
        w_sync_err = bus.i_valid && bus.i_sof;
        w_complete = bus.i_valid && !bus.i_sof && wtc;
      end
      W_HOLD:  w_drop = bus.i_valid && bus.i_sof;
      default: w_drop = 1'b0;
    endcase
  end

  // Reader state register
  always_ff @(posedge i_clk) begin
    if (!i_rstn) r_state_q <= R_IDLE;
    else         r_state_q <= r_state_d;
  end

  // Reader next state follows the display request
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:   if (bus.i_req)  r_state_d = R_ACTIVE;
      R_ACTIVE: if (!bus.i_req) r_state_d = R_IDLE;
      default:  r_state_d = R_IDLE;
    endcase
  end

  // Reader issues one read per cycle while the FIFO has room; counter held at 0 when idle
  always_comb begin
    r_issue = (r_state_q == R_ACTIVE) && bus.i_req && !bus.i_almostfull;
    r_clr   = (r_state_q != R_ACTIVE) || !bus.i_req;
  end

`ifdef FB_PINGPONG_EN
  logic r_end, wbank_q, rbank_q, pending_q;

  assign r_end = (r_state_q == R_ACTIVE) && (!bus.i_req || (r_issue && rtc));
  assign swap  = r_end && (pending_q || w_complete);
  assign wbase = wbank_q ? AW'(FRAME_PIXELS) : '0;
  assign rbase = rbank_q ? AW'(FRAME_PIXELS) : '0;

  // Bank ownership: the finished bank goes to the reader only when it reaches a frame end
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      wbank_q   <= 1'b0;
      rbank_q   <= 1'b1;
      pending_q <= 1'b0;
    end else if (swap) begin
      rbank_q   <= wbank_q;
      wbank_q   <= ~wbank_q;
      pending_q <= 1'b0;
    end else if (w_complete) begin
      pending_q <= 1'b1;
    end
  end

  assign bus.o_wbank = wbank_q;
  assign bus.o_rbank = rbank_q;
  assign bus.o_drop  = drop_q;
`else
  logic unused_rtc;

  assign unused_rtc  = rtc;
  assign swap        = 1'b0;
  assign wbase       = '0;
  assign rbase       = '0;
  assign bus.o_wbank = 1'b0;
  assign bus.o_rbank = 1'b0;
  assign bus.o_drop  = 1'b0;
`endif

  // Registered BRAM ports, flag pulses and the 2-stage read-issue pipe
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      mem_wr_q   <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      raddr_q    <= '0;
      rd_pipe_q  <= 1'b0;
      fifo_wr_q  <= 1'b0;
      drop_q     <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      mem_wr_q   <= w_accept;
      drop_q     <= w_drop && !swap;
      sync_err_q <= w_sync_err;
      if (w_accept) begin
        waddr_q <= wbase + (w_restart ? '0 : AW'(wcnt));
        wdata_q <= bus.i_data;
      end
      if (r_issue) raddr_q <= rbase + AW'(rcnt);
      rd_pipe_q <= r_issue;
      fifo_wr_q <= rd_pipe_q;
    end
  end

  assign bus.o_mem_wr    = mem_wr_q;
  assign bus.o_mem_waddr = waddr_q;
  assign bus.o_mem_wdata = wdata_q;
  assign bus.o_mem_raddr = raddr_q;
  assign bus.o_fifo_wr   = fifo_wr_q;
  assign bus.o_sync_err  = sync_err_q;

endmodule
